// File: rtl/mc_ctrl_pkg.sv
// ============================================================================
// mc_ctrl_pkg : shared types and encodings for the multi-cycle controller
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

package mc_ctrl_pkg;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEM_ADDR = 4'd2,
      S_MEM_RD   = 4'd3,
      S_WB_LW    = 4'd4,
      S_MEM_WR   = 4'd5,
      S_EXEC_R   = 4'd6,
      S_WB_R     = 4'd7,
      S_BRANCH   = 4'd8,
      S_JUMP     = 4'd9,
      S_EXEC_I   = 4'd10,
      S_WB_I     = 4'd11
   } state_e;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_ADDI  = 6'b001000;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [1:0] SRCB_RT     = 2'b00;
   localparam logic [1:0] SRCB_FOUR   = 2'b01;
   localparam logic [1:0] SRCB_IMM    = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   typedef struct packed {
      logic       pc_write;
      logic       ir_write;
      logic       i_or_d;
      logic       mem_read;
      logic       mem_write;
      logic       reg_write;
      logic       reg_dst;
      logic       mem_to_reg;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic [1:0] pc_source;
   } ctrl_t;

   // Unsupported opcodes dispatch back to FETCH; the caller flags them.
   function automatic state_e decode_dispatch(input logic [5:0] op);
      case (op)
         OP_RTYPE:      decode_dispatch = S_EXEC_R;
         OP_LW, OP_SW:  decode_dispatch = S_MEM_ADDR;
         OP_BEQ:        decode_dispatch = S_BRANCH;
         OP_J:          decode_dispatch = S_JUMP;
         OP_ADDI:       decode_dispatch = S_EXEC_I;
         default:       decode_dispatch = S_FETCH;
      endcase
   endfunction

endpackage

`default_nettype wire

// File: rtl/mc_ctrl_outdec.sv
// ============================================================================
// mc_ctrl_outdec : combinational control-word decoder from the current state
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module mc_ctrl_outdec
   import mc_ctrl_pkg::*;
(
   input  state_e state_i,
   input  logic   start_i,
   input  logic   mem_ready_i,
   input  logic   zero_i,
   output ctrl_t  ctrl_o
);

   always_comb begin
      ctrl_o = '0;
      case (state_i)
         S_FETCH: begin
            ctrl_o.mem_read  = start_i;
            ctrl_o.ir_write  = start_i & mem_ready_i;
            ctrl_o.pc_write  = start_i & mem_ready_i;
            ctrl_o.alu_src_b = SRCB_FOUR;
            ctrl_o.alu_op    = ALUOP_ADD;
            ctrl_o.pc_source = PCSRC_ALU;
         end
         S_DECODE: begin
            // Branch target is precomputed here into ALUOut.
            ctrl_o.alu_src_b = SRCB_IMM_SH;
            ctrl_o.alu_op    = ALUOP_ADD;
         end
         S_MEM_ADDR: begin
            ctrl_o.alu_src_a = 1'b1;
            ctrl_o.alu_src_b = SRCB_IMM;
            ctrl_o.alu_op    = ALUOP_ADD;
         end
         S_MEM_RD: begin
            ctrl_o.mem_read = 1'b1;
            ctrl_o.i_or_d   = 1'b1;
         end
         S_WB_LW: begin
            ctrl_o.reg_write  = 1'b1;
            ctrl_o.mem_to_reg = 1'b1;
         end
         S_MEM_WR: begin
            ctrl_o.mem_write = 1'b1;
            ctrl_o.i_or_d    = 1'b1;
         end
         S_EXEC_R: begin
            ctrl_o.alu_src_a = 1'b1;
            ctrl_o.alu_src_b = SRCB_RT;
            ctrl_o.alu_op    = ALUOP_FUNCT;
         end
         S_WB_R: begin
            ctrl_o.reg_write = 1'b1;
            ctrl_o.reg_dst   = 1'b1;
         end
         S_BRANCH: begin
            ctrl_o.alu_src_a = 1'b1;
            ctrl_o.alu_src_b = SRCB_RT;
            ctrl_o.alu_op    = ALUOP_SUB;
            ctrl_o.pc_source = PCSRC_ALUOUT;
            ctrl_o.pc_write  = zero_i;
         end
         S_JUMP: begin
            ctrl_o.pc_source = PCSRC_JUMP;
            ctrl_o.pc_write  = 1'b1;
         end
         S_EXEC_I: begin
            ctrl_o.alu_src_a = 1'b1;
            ctrl_o.alu_src_b = SRCB_IMM;
            ctrl_o.alu_op    = ALUOP_ADD;
         end
         S_WB_I: begin
            ctrl_o.reg_write = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/mc_control_fsm.sv
// ============================================================================
// mc_control_fsm : multi-cycle CPU main controller (state register, sequencing,
// sticky illegal flag). Optional MC_CTRL_PERF_EN adds cycle/instret counters.
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module mc_control_fsm
   import mc_ctrl_pkg::*;
#(
   parameter int OP_W    = 6,
   parameter int STATE_W = 4
)(
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               start_i,
   input  logic [OP_W-1:0]    op_i,
   input  logic               zero_i,
   input  logic               mem_ready_i,
   output logic               pc_write_o,
   output logic               ir_write_o,
   output logic               i_or_d_o,
   output logic               mem_read_o,
   output logic               mem_write_o,
   output logic               reg_write_o,
   output logic               reg_dst_o,
   output logic               mem_to_reg_o,
   output logic               alu_src_a_o,
   output logic [1:0]         alu_src_b_o,
   output logic [1:0]         alu_op_o,
   output logic [1:0]         pc_source_o,
   output logic [STATE_W-1:0] state_o,
   output logic               illegal_o
`ifdef MC_CTRL_PERF_EN
   ,
   output logic [31:0]        cycle_cnt_o,
   output logic [31:0]        instret_o
`endif
);

   state_e state_q, state_d;
   logic   illegal_q, illegal_d;
   state_e dispatch;
   ctrl_t  ctrl;

   assign dispatch = decode_dispatch(op_i);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= S_FETCH;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         illegal_q <= illegal_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      illegal_d = illegal_q;
      case (state_q)
         S_FETCH:    if (start_i && mem_ready_i) state_d = S_DECODE;
         S_DECODE: begin
            state_d = dispatch;
            if (dispatch == S_FETCH) illegal_d = 1'b1;
         end
         S_MEM_ADDR: state_d = (op_i == OP_LW) ? S_MEM_RD : S_MEM_WR;
         S_MEM_RD:   if (mem_ready_i) state_d = S_WB_LW;
         S_MEM_WR:   if (mem_ready_i) state_d = S_FETCH;
         S_EXEC_R:   state_d = S_WB_R;
         S_EXEC_I:   state_d = S_WB_I;
         S_WB_LW, S_WB_R, S_WB_I, S_BRANCH, S_JUMP:
                     state_d = S_FETCH;
         default:    state_d = S_FETCH;
      endcase
   end

   mc_ctrl_outdec u_outdec (
      .state_i     (state_q),
      .start_i     (start_i),
      .mem_ready_i (mem_ready_i),
      .zero_i      (zero_i),
      .ctrl_o      (ctrl)
   );

   assign pc_write_o   = ctrl.pc_write;
   assign ir_write_o   = ctrl.ir_write;
   assign i_or_d_o     = ctrl.i_or_d;
   assign mem_read_o   = ctrl.mem_read;
   assign mem_write_o  = ctrl.mem_write;
   assign reg_write_o  = ctrl.reg_write;
   assign reg_dst_o    = ctrl.reg_dst;
   assign mem_to_reg_o = ctrl.mem_to_reg;
   assign alu_src_a_o  = ctrl.alu_src_a;
   assign alu_src_b_o  = ctrl.alu_src_b;
   assign alu_op_o     = ctrl.alu_op;
   assign pc_source_o  = ctrl.pc_source;
   assign state_o      = STATE_W'(state_q);
   assign illegal_o    = illegal_q;

`ifdef MC_CTRL_PERF_EN
   logic [31:0] cycle_cnt_q, instret_q;
   logic        retire;

   // Illegal opcodes leave from DECODE, so they never count as retired.
   always_comb begin
      case (state_q)
         S_WB_LW, S_WB_R, S_WB_I, S_BRANCH, S_JUMP: retire = 1'b1;
         S_MEM_WR:                                  retire = mem_ready_i;
         default:                                   retire = 1'b0;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cycle_cnt_q <= '0;
         instret_q   <= '0;
      end else begin
         if (start_i) cycle_cnt_q <= cycle_cnt_q + 32'd1;
         if (retire)  instret_q   <= instret_q + 32'd1;
      end
   end

   assign cycle_cnt_o = cycle_cnt_q;
   assign instret_o   = instret_q;
`endif

endmodule

`default_nettype wire
